// File: rtl/ctrl_conv_input.sv
// Input-side control for the convolution datapath: steers the operand stream into F then X memory and kicks the MAC.
// Optional feature: define CONV_FILTER_RELOAD_EN to reload the filter on every frame (default: load once after reset).
module ctrl_conv_input #(
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_SIZE       = 8,
    parameter int F_MEM_ADDR_WIDTH = 2,
    parameter int X_MEM_ADDR_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid_x,
    output logic                        s_ready_x,
    input  logic                        conv_done,
    output logic                        wr_en_f,
    output logic [F_MEM_ADDR_WIDTH-1:0] addr_f,
    output logic                        wr_en_x,
    output logic [X_MEM_ADDR_WIDTH-1:0] addr_x,
    output logic                        conv_start,
    output logic                        f_loaded
);

    typedef enum logic [1:0] {
        LOAD_F = 2'd0,
        LOAD_X = 2'd1,
        CONV   = 2'd2
    } state_t;

    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);

    state_t state;
    logic   acc;

    // Ready is gated by reset so no word is accepted (and lost) while reset is held.
    assign s_ready_x = !reset && (state != CONV);
    assign acc       = s_valid_x && s_ready_x;
    assign wr_en_f   = acc && (state == LOAD_F);
    assign wr_en_x   = acc && (state == LOAD_X);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD_F;
            addr_f     <= '0;
            addr_x     <= '0;
            conv_start <= 1'b0;
            f_loaded   <= 1'b0;
        end else begin
            case (state)
                LOAD_F: begin
                    if (acc) begin
                        if (addr_f == F_LAST) begin
                            addr_f   <= '0;
                            f_loaded <= 1'b1;
                            state    <= LOAD_X;
                        end else begin
                            addr_f <= addr_f + F_MEM_ADDR_WIDTH'(1);
                        end
                    end
                end
                LOAD_X: begin
                    if (acc) begin
                        if (addr_x == X_LAST) begin
                            addr_x     <= '0;
                            conv_start <= 1'b1;
                            state      <= CONV;
                        end else begin
                            addr_x <= addr_x + X_MEM_ADDR_WIDTH'(1);
                        end
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        conv_start <= 1'b0;
`ifdef CONV_FILTER_RELOAD_EN
                        f_loaded   <= 1'b0;
                        state      <= LOAD_F;
`else
                        state      <= LOAD_X;
`endif
                    end
                end
                default: begin
                    state <= LOAD_F;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_conv_input.sv
// Randomized self-checking bench for ctrl_conv_input against a word-count reference model.
// Honors CONV_FILTER_RELOAD_EN in the same way as the design.
module tb_ctrl_conv_input;

    localparam int NF = 4;
    localparam int NX = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid_x;
    logic       s_ready_x;
    logic       conv_done;
    logic       wr_en_f;
    logic [1:0] addr_f;
    logic       wr_en_x;
    logic [2:0] addr_x;
    logic       conv_start;
    logic       f_loaded;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CONV_FILTER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    // Reference model: words accepted in this frame, how many of them go to F, and phase flags.
    int cnt;
    int base;
    bit m_conv;
    bit m_floaded;

    ctrl_conv_input dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid_x  (s_valid_x),
        .s_ready_x  (s_ready_x),
        .conv_done  (conv_done),
        .wr_en_f    (wr_en_f),
        .addr_f     (addr_f),
        .wr_en_x    (wr_en_x),
        .addr_x     (addr_x),
        .conv_start (conv_start),
        .f_loaded   (f_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model at the rising edge.
    task automatic step(input bit v, input bit done, input bit rst);
        bit e_ready, e_acc, in_f;
        s_valid_x = v;
        conv_done = done;
        reset     = rst;
        #1;
        e_ready = !rst && !m_conv;
        e_acc   = v && e_ready;
        in_f    = (cnt < base);
        check("s_ready_x",  32'(s_ready_x),  32'(e_ready));
        check("wr_en_f",    32'(wr_en_f),    32'(e_acc && in_f));
        check("wr_en_x",    32'(wr_en_x),    32'(e_acc && !in_f));
        check("addr_f",     32'(addr_f),     in_f ? 32'(cnt) : 32'd0);
        check("addr_x",     32'(addr_x),     (!in_f && !m_conv) ? 32'(cnt - base) : 32'd0);
        check("conv_start", 32'(conv_start), 32'(m_conv));
        check("f_loaded",   32'(f_loaded),   32'(m_floaded));
        @(posedge clk);
        if (rst) begin
            cnt = 0; base = NF; m_conv = 0; m_floaded = 0;
        end else if (m_conv) begin
            if (done) begin
                m_conv = 0;
                cnt    = 0;
                base   = RELOAD ? NF : 0;
                if (RELOAD) m_floaded = 0;
            end
        end else if (e_acc) begin
            cnt++;
            if (base > 0 && cnt == base) m_floaded = 1;
            if (cnt == base + NX) m_conv = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        cnt = 0; base = NF; m_conv = 0; m_floaded = 0;
        reset = 1'b1; s_valid_x = 1'b0; conv_done = 1'b0;
        @(negedge clk);
        repeat (2) step(1'b1, 1'b0, 1'b1);

        // Continuous stream, then long CONV with valid held, then conv_done.
        repeat (NF + NX) step(1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Second frame with toggling valid and a stray conv_done while loading.
        for (int i = 0; i < 2 * (NF + NX); i++)
            step(i[0] == 1'b0, i == 5, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Reset mid-load after 6 accepts of a fresh filter+sample load.
        step(1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        repeat (NF + 2) step(1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 300) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_conv_input.md
# ctrl_conv_input

Input-side control for the convolution datapath. It accepts the serial AXI-stream operand stream, loads filter coefficients into F memory and then samples into X memory, raises `conv_start` once both memories are populated, and holds it until the output controller signals `conv_done`. It then re-arms for the next frame. Together with the output controller it closes the stream-in / stream-out loop around the MAC datapath.

## Interface
Parameters:
- `F_MEM_SIZE`, 4: number of filter words per load.
- `X_MEM_SIZE`, 8: number of sample words per frame.
- `F_MEM_ADDR_WIDTH`, 2: F memory address width; must satisfy 2^width ≥ `F_MEM_SIZE`.
- `X_MEM_ADDR_WIDTH`, 3: X memory address width; must satisfy 2^width ≥ `X_MEM_SIZE`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid_x`  in  1  upstream word valid.
- `s_ready_x`  out  1  block can accept a word.
- `conv_done`  in  1  final output word accepted (from output controller).
- `wr_en_f`  out  1  F memory write strobe.
- `addr_f`  out  `F_MEM_ADDR_WIDTH`  F memory write address.
- `wr_en_x`  out  1  X memory write strobe.
- `addr_x`  out  `X_MEM_ADDR_WIDTH`  X memory write address.
- `conv_start`  out  1  level: memories loaded, convolution in progress.
- `f_loaded`  out  1  F memory holds a valid filter.

## Operation
- States: `LOAD_F`, `LOAD_X`, `CONV`. Reset enters `LOAD_F`.
- Accept: `acc = s_valid_x && s_ready_x`.
- `s_ready_x` is 1 in `LOAD_F` and `LOAD_X`. It is 0 in `CONV` and in any cycle with `reset` high.
- `wr_en_f = acc` in `LOAD_F`; `wr_en_x = acc` in `LOAD_X`. Both are combinational and 0 otherwise. Data bypasses this block.
- `LOAD_F`:
  - Each `acc` increments `addr_f`.
  - On `acc` with `addr_f == F_MEM_SIZE-1`: `addr_f` returns to 0, `f_loaded` is set to 1, and the state moves to `LOAD_X`.
- `LOAD_X`:
  - Each `acc` increments `addr_x`.
  - On `acc` with `addr_x == X_MEM_SIZE-1`: `addr_x` returns to 0, the state moves to `CONV`, and `conv_start` goes to 1.
- `CONV`:
  - `conv_start` holds at 1.
  - On `conv_done == 1`: `conv_start` goes to 0 and the state moves to the reload state (see Configuration).
- `conv_done` is ignored outside `CONV`.
- `s_valid_x` without `s_ready_x` causes no write and no counter change.
- Counters compare against `SIZE-1` explicitly and never rely on natural wrap, so non-power-of-two sizes are legal.
- Reset mid-operation: state, both addresses, `conv_start` and `f_loaded` all clear in the same cycle, and any partially loaded frame is discarded.

## Timing
- Reset values: `s_ready_x` 0 while `reset` is high, then 1; `wr_en_f`/`wr_en_x` 0; `addr_f`/`addr_x` 0; `conv_start` 0; `f_loaded` 0.
- Write strobes fire in the same cycle as the handshake. The address shown in that cycle is the write address, and it advances on the following edge.
- `conv_start` rises on the edge after the last X handshake. Its rising edge is the output controller's kick.
- `conv_start` falls on the edge after `conv_done`.
- `s_ready_x` re-asserts the cycle after `conv_done`. Minimum gap from the last output to the first new input accept is 1 cycle.
- Back-to-back streaming with `s_valid_x` held high:
  - `F_MEM_SIZE + X_MEM_SIZE` cycles per load with reload.
  - `X_MEM_SIZE` cycles per load without reload.

## Configuration
- Macro: `CONV_FILTER_RELOAD_EN`.
- Defined: every frame reloads the filter. After `conv_done` the state goes to `LOAD_F` and `f_loaded` clears.
- Undefined: the filter is loaded once after reset. After `conv_done` the state goes to `LOAD_X` and `f_loaded` stays 1. Re-entering `LOAD_F` requires `reset`.

## Test plan
All scenarios use defaults F=4, X=8.
- Reset, then 12 words with `s_valid_x` high continuously -> `wr_en_f` for cycles 0–3 with `addr_f` 0..3; `wr_en_x` for cycles 4–11 with `addr_x` 0..7; `conv_start`=1 from cycle 12; `s_ready_x`=0.
- Same stream with `s_valid_x` toggling every other cycle -> identical address sequences, no write in low cycles, `conv_start` after the 12th accept.
- In `CONV`, hold `s_valid_x` high for 20 cycles, then pulse `conv_done` -> no writes during `CONV`; `conv_start` 0 and `s_ready_x` 1 on the next cycle.
- Second frame with macro undefined: the next 8 words go to X (`addr_x` 0..7), no `wr_en_f`, and `f_loaded` stays 1. With the macro defined, the first 4 go to F.
- Assert `reset` after 6 accepts (filter done, `addr_x`=2) -> all outputs return to reset values; the next 4 accepts write F 0..3.
- Pulse `conv_done` during `LOAD_X` -> no state change, and loading continues normally.
